// File: rtl/signal_pipe_pkg.sv
// Shared constants and sizing helpers for the handshaked delay pipeline.
package signal_pipe_pkg;

  localparam int STAGE_FIRST = 0;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((32'sd1 <<< r) < n) r = r + 1;
    return r;
  endfunction

  // Occupancy counter width: enough to hold 0..L, never narrower than one bit.
  function automatic int occ_w(input int l);
    int c;
    c = clog2(l + 1);
    return (c < 1) ? 1 : c;
  endfunction

endpackage

// File: rtl/signal_pipe_hs_occ_chk.sv
// Occupancy consistency checker, only present when SIGNAL_PIPE_HS_OCC_EN is defined.
`ifdef SIGNAL_PIPE_HS_OCC_EN
module signal_pipe_hs_occ_chk #(
  parameter int L     = 1,
  parameter int OCC_W = 1
) (
  input logic             clk,
  input logic             rst_n,
  input logic [L-1:0]     v,
  input logic [OCC_W-1:0] occ
);

  a_occ_matches_valid: assert property (@(posedge clk) disable iff (!rst_n)
    32'(occ) == 32'($countones(v)));

endmodule
`endif

// File: rtl/signal_pipe_hs_stage.sv
// One valid/data slice of the handshaked pipeline; r tells the upstream
// slice whether this one can take a word this cycle.
module signal_pipe_hs_stage
  import signal_pipe_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         prev_v,
  input  logic [W-1:0] prev_d,
  input  logic         next_r,
  output logic         v,
  output logic [W-1:0] d,
  output logic         r
);

  logic         v_r;
  logic [W-1:0] d_r;

  assign r = ~v_r | next_r;

  // Valid bit: flush empties the slice, otherwise it follows upstream when free to move
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_r <= 1'b0;
    end else if (flush) begin
      v_r <= 1'b0;
    end else if (r) begin
      v_r <= prev_v;
    end
  end

  // Data register: loads only when a real word enters, so bubbles keep old contents
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_r <= {W{1'b0}};
    end else if (!flush && r && prev_v) begin
      d_r <= prev_d;
    end
  end

  assign v = v_r;
  assign d = d_r;

endmodule

// File: rtl/signal_pipe_hs.sv
// W-bit, L-stage stallable delay pipeline with valid/ready on both ends.
// Define SIGNAL_PIPE_HS_OCC_EN to add the registered occupancy output occ.
module signal_pipe_hs
  import signal_pipe_pkg::*;
#(
  parameter int W = 1,
  parameter int L = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
`ifdef SIGNAL_PIPE_HS_OCC_EN
  ,
  output logic [occ_w(L)-1:0] occ
`endif
);

  generate
    if (L == 0) begin : g_bypass
      assign in_ready  = out_ready & ~flush;
      assign out_valid = in_valid & ~flush;
      assign out_data  = in_data;
`ifdef SIGNAL_PIPE_HS_OCC_EN
      assign occ = {occ_w(L){1'b0}};
`endif
    end else begin : g_pipe
      logic [L-1:0] v_s;
      logic [W-1:0] d_s [L];

      for (genvar i = 0; i < L; i++) begin : g_stage
        logic         prev_v_s;
        logic [W-1:0] prev_d_s;
        logic         next_r_s;
        logic         r_s;

        if (i == STAGE_FIRST) begin : g_head
          assign prev_v_s = in_valid;
          assign prev_d_s = in_data;
        end else begin : g_body
          assign prev_v_s = v_s[i-1];
          assign prev_d_s = d_s[i-1];
        end

        // Ready ripples back from the output through every stage in one cycle
        if (i == L - 1) begin : g_tail
          assign next_r_s = out_ready;
        end else begin : g_mid
          assign next_r_s = g_stage[i+1].r_s;
        end

        signal_pipe_hs_stage #(.W(W)) u_stage (
          .clk    (clk),
          .rst_n  (rst_n),
          .flush  (flush),
          .prev_v (prev_v_s),
          .prev_d (prev_d_s),
          .next_r (next_r_s),
          .v      (v_s[i]),
          .d      (d_s[i]),
          .r      (r_s)
        );
      end

      assign in_ready  = g_stage[0].r_s & ~flush;
      assign out_valid = v_s[L-1];
      assign out_data  = d_s[L-1];

`ifdef SIGNAL_PIPE_HS_OCC_EN
      localparam int OCC_W = occ_w(L);
      logic [OCC_W-1:0] occ_r;
      logic             acc_s;
      logic             drn_s;

      assign acc_s = in_valid & in_ready;
      assign drn_s = out_valid & out_ready;

      // Occupancy: words entering minus words leaving, cleared with the pipe
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          occ_r <= {OCC_W{1'b0}};
        end else if (flush) begin
          occ_r <= {OCC_W{1'b0}};
        end else begin
          occ_r <= occ_r + OCC_W'(acc_s) - OCC_W'(drn_s);
        end
      end

      assign occ = occ_r;

      signal_pipe_hs_occ_chk #(.L(L), .OCC_W(OCC_W)) u_occ_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .v     (v_s),
        .occ   (occ_r)
      );
`endif
    end
  endgenerate

endmodule

// File: tb/tb_signal_pipe_hs.sv
// Bench for signal_pipe_hs: an L=3 pipe against a queue-of-words model,
// plus an L=0 bypass instance checked combinationally.
module tb_signal_pipe_hs;
  import signal_pipe_pkg::*;

  localparam int W  = 8;
  localparam int L  = 3;
  localparam int ZW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  in_data, out_data;
  logic          z_in_valid, z_in_ready, z_out_valid, z_out_ready;
  logic [ZW-1:0] z_in_data, z_out_data;
`ifdef SIGNAL_PIPE_HS_OCC_EN
  logic [occ_w(L)-1:0] occ;
  logic [occ_w(0)-1:0] z_occ;
`endif

  always #5 clk = ~clk;

  signal_pipe_hs #(.W(W), .L(L)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef SIGNAL_PIPE_HS_OCC_EN
    , .occ(occ)
`endif
  );

  signal_pipe_hs #(.W(ZW), .L(0)) dut_z (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(z_in_valid), .in_ready(z_in_ready), .in_data(z_in_data),
    .out_valid(z_out_valid), .out_ready(z_out_ready), .out_data(z_out_data)
`ifdef SIGNAL_PIPE_HS_OCC_EN
    , .occ(z_occ)
`endif
  );

  // Model: words in flight in order, each with the earliest edge it can
  // reach the output (accept edge + L-1). The head is visible once that
  // edge has passed; words behind a stalled head simply wait their turn.
  typedef struct {
    logic [W-1:0] d;
    int           e;
  } ent_t;

  ent_t q[$];
  int   ecnt   = 0;
  int   checks = 0;
  int   errors = 0;
  logic stalled = 1'b0;
  logic [W-1:0] held_d = 8'h00;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic iv, input logic [W-1:0] id, input logic ordy, input logic fl);
    logic exp_ir, exp_ov, acc, drn;
    in_valid    = iv;
    in_data     = id;
    out_ready   = ordy;
    flush       = fl;
    z_in_valid  = 1'($urandom_range(0, 1));
    z_out_ready = 1'($urandom_range(0, 1));
    z_in_data   = 4'($urandom);
    #4;
    exp_ir = !fl && ((q.size() < L) || ordy);
    exp_ov = 1'b0;
    if (q.size() > 0) exp_ov = (ecnt >= q[0].e);
    check_eq("in_ready", 32'(in_ready), 32'(exp_ir));
    check_eq("out_valid", 32'(out_valid), 32'(exp_ov));
    if (exp_ov) check_eq("out_data", 32'(out_data), 32'(q[0].d));
    check_eq("z_in_ready", 32'(z_in_ready), 32'(z_out_ready & ~fl));
    check_eq("z_out_valid", 32'(z_out_valid), 32'(z_in_valid & ~fl));
    check_eq("z_out_data", 32'(z_out_data), 32'(z_in_data));
    acc = iv & exp_ir;
    drn = exp_ov & ordy;
    stalled = iv & ~exp_ir;
    held_d  = id;
    @(posedge clk);
    ecnt++;
    if (drn) void'(q.pop_front());
    if (fl) q.delete();
    if (acc) q.push_back('{d: id, e: ecnt + L - 1});
    #1;
`ifdef SIGNAL_PIPE_HS_OCC_EN
    check_eq("occ", 32'(occ), 32'(q.size()));
    check_eq("z_occ", 32'(z_occ), 32'd0);
`endif
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    z_in_valid = 1'b0; z_in_data = 4'h0; z_out_ready = 1'b0;
    #1;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_data", 32'(out_data), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Back-to-back stream with no stall
    for (int i = 1; i <= 10; i++) step(1'b1, 8'(i), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Stall until full, then release with a simultaneous accept/drain
    step(1'b1, 8'hA0, 1'b0, 1'b0);
    step(1'b1, 8'hA1, 1'b0, 1'b0);
    step(1'b1, 8'hA2, 1'b0, 1'b0);
    step(1'b1, 8'hA3, 1'b0, 1'b0);
    step(1'b1, 8'hA3, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Bubbles between words; empty-slot data is junk
    step(1'b1, 8'h11, 1'b1, 1'b0);
    step(1'b0, 8'($urandom), 1'b1, 1'b0);
    step(1'b1, 8'h22, 1'b1, 1'b0);
    step(1'b0, 8'($urandom), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Flush a full pipe while the head is being taken
    step(1'b1, 8'h31, 1'b0, 1'b0);
    step(1'b1, 8'h32, 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b0, 1'b0);
    step(1'b1, 8'h34, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Asynchronous reset with two words in flight
    step(1'b1, 8'h41, 1'b1, 1'b0);
    step(1'b1, 8'h42, 1'b1, 1'b0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("arst_out_valid", 32'(out_valid), 32'd0);
    check_eq("arst_out_data", 32'(out_data), 32'd0);
    check_eq("arst_in_ready", 32'(in_ready), 32'd1);
    q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1'b1, 8'h55, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Randomized traffic, holding data while the pipe refuses it
    for (int i = 0; i < 400; i++) begin
      logic iv, ordy, fl;
      logic [W-1:0] id;
      if (stalled) begin
        iv = 1'b1;
        id = held_d;
      end else begin
        iv = ($urandom_range(0, 9) < 7);
        id = 8'($urandom);
      end
      ordy = ($urandom_range(0, 9) < 6);
      fl   = ($urandom_range(0, 19) == 0);
      step(iv, id, ordy, fl);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
